// File: rtl/scoreboard.sv
// Register scoreboard between decode and execute: per-register pending-write counters,
// RAW/WAW-limit stalls, and a RUN/DRAIN/SERIAL gate for serializing instructions.
module scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        D_valid_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        use_rs1_i,
  input  logic        use_rs2_i,
  input  logic        wenReg_i,
  input  logic        wenCsr_i,
  input  logic        E_ready_i,
  output logic        d_valid_o,
  output logic        d_ready_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        wb_wenReg_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned CW   = 3;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned SW   = 32;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] SERIAL = 2'd2;

  logic [CW-1:0] cnt_q  [1:NREG-1];
  logic [CW-1:0] cnt_d  [1:NREG-1];
  logic [CW-1:0] cnt_rd [0:NREG-1];
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          any_nz;
  logic          raw;
  logic          waw;
  logic          gate;
  logic          stall;
  logic          fire;
  logic          underflow;

  // Read view of the counters with x0 hardwired to zero
  always_comb begin
    cnt_rd[0] = '0;
    any_nz    = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      cnt_rd[i] = cnt_q[i];
      any_nz    = any_nz | (cnt_q[i] != '0);
    end
  end

  // Hazard detection and handshake, all against pre-edge counter values
  always_comb begin
    raw = (use_rs1_i && (cnt_rd[rs1_i] != '0)) || (use_rs2_i && (cnt_rd[rs2_i] != '0));
    waw = wenReg_i && (rd_i != '0) && (cnt_rd[rd_i] == CW'(MAX_INFLIGHT));
    case (state_q)
      RUN:     gate = D_valid_i && wenCsr_i;
      DRAIN:   gate = any_nz;
      default: gate = 1'b1;
    endcase
    stall     = raw || waw || gate;
    d_valid_o = D_valid_i && !stall && !flush_i;
    d_ready_o = E_ready_i && !stall;
    fire      = d_valid_o && E_ready_i;
    busy_o    = (state_q != RUN) || any_nz;
  end

  // Serialization FSM next-state
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (D_valid_i && wenCsr_i) state_d = DRAIN;
        DRAIN:   if (fire) state_d = SERIAL;
        SERIAL:  if (wb_valid_i) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Counter next values; a matched issue+writeback on one register cancels out
  always_comb begin
    underflow = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      logic inc;
      logic dec;
      inc      = fire && wenReg_i && (rd_i == RW'(i));
      dec      = wb_valid_i && wb_wenReg_i && (wb_rd_i == RW'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) underflow = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) cnt_q[i] <= flush_i ? CW'(0) : cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (!flush_i && underflow)          err_o       <= 1'b1;
      if (D_valid_i && stall && !flush_i) stall_cnt_o <= stall_cnt_o + SW'(1);
    end
  end

endmodule
